// File: rtl/bounce_sprite_engine.sv
// Bouncing sprite physics sequencer with registered per-pixel ring/heart hit test.
// One sprite is stepped per clock after each enabled frame_end strobe.
module bounce_sprite_engine #(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_SIZE = 32,
  parameter int RANGE_X     = 608,
  parameter int FLOOR_Y     = 384,
  parameter int SPEED_X     = 9,
  parameter int INIT_VEL_Y  = 21,
  parameter int PULSE_MIN   = 9,
  parameter int PULSE_MAX   = 200,
  parameter int PULSE_STEP  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_end,
  input  logic                   enable,
  input  logic [9:0]             h,
  input  logic [9:0]             v,
  output logic                   busy,
  output logic [NUM_SPRITES-1:0] bounce,
  output logic                   hit,
  output logic                   hit_heart,
  output logic [1:0]             hit_id
);

  localparam int IW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int HALF = SPRITE_SIZE / 2;
  localparam int DW   = $clog2(SPRITE_SIZE) + 1;
  localparam logic [10:0] RING_R2 = 11'(HALF * HALF - 15);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t state, state_nxt;
  logic [IW-1:0] index;

  logic [11:0]        x   [NUM_SPRITES];
  logic signed [11:0] y   [NUM_SPRITES];
  logic signed [7:0]  vel [NUM_SPRITES];
  logic               dir [NUM_SPRITES];

  logic [10:0] pulse;
  logic        rising;

  logic start, last;

  assign start = (state == IDLE) && frame_end && enable;
  assign last  = (index == IW'(NUM_SPRITES - 1));
  assign busy  = (state == UPDATE);

  // Dropping enable mid-run stalls the sequencer so all state freezes.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = UPDATE;
      UPDATE:  if (enable && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [11:0]        cx, nx;
  logic signed [11:0] cy, ny, vext, negv;
  logic signed [7:0]  cvel, nvel;
  logic               cdir, ndir, land;
  logic [12:0]        sum;

  always_comb begin
    cx   = x[index];
    cy   = y[index];
    cvel = vel[index];
    cdir = dir[index];
    sum  = {1'b0, cx} + 13'(SPEED_X);
    nx   = cx;
    ndir = cdir;
    if (cdir) begin
      if (sum[12:2] >= 11'(RANGE_X)) begin
        nx   = 12'(RANGE_X * 4);
        ndir = 1'b0;
      end else begin
        nx = sum[11:0];
      end
    end else if (cx < 12'(SPEED_X)) begin
      nx   = '0;
      ndir = 1'b1;
    end else begin
      nx = cx - 12'(SPEED_X);
    end
    vext = {{4{cvel[7]}}, cvel};
    negv = -vext;
    land = (cvel < 0) && (cy <= negv);
    if (land) begin
      ny   = '0;
      nvel = 8'(INIT_VEL_Y - 2) + {6'd0, cx[3:2]};
    end else begin
      ny   = cy + vext;
      nvel = cvel - 8'sd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      index  <= '0;
      pulse  <= 11'(PULSE_MIN);
      rising <= 1'b1;
      bounce <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x[i]   <= 12'(4 * i * (RANGE_X / NUM_SPRITES));
        y[i]   <= '0;
        vel[i] <= 8'(INIT_VEL_Y - i);
        dir[i] <= 1'b1;
      end
    end else begin
      state  <= state_nxt;
      bounce <= '0;
      if (start) begin
        index <= '0;
        if (rising) begin
          if (pulse >= 11'(PULSE_MAX)) rising <= 1'b0;
          else pulse <= pulse + 11'(PULSE_STEP);
        end else begin
          if (pulse < 11'(PULSE_MIN + PULSE_STEP)) rising <= 1'b1;
          else pulse <= pulse - 11'(PULSE_STEP);
        end
      end
      if (busy && enable) begin
        x[index]      <= nx;
        y[index]      <= ny;
        vel[index]    <= nvel;
        dir[index]    <= ndir;
        bounce[index] <= land;
        index         <= last ? '0 : index + 1'b1;
      end
    end
  end

  logic [NUM_SPRITES-1:0] ring, heart;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic [9:0]           px, py;
    logic [10:0]          hx, pxe, dxw;
    logic signed [11:0]   vs, bot, top, ctr, dyw;
    logic signed [DW-1:0] dx, dy;
    logic signed [2*DW-1:0] sx, sy;
    logic [2*DW:0]        d2s;
    logic [10:0]          d2;
    logic                 in_box;

    assign px  = x[g][11:2];
    assign py  = y[g][9:0];
    assign hx  = {1'b0, h};
    assign pxe = {1'b0, px};
    assign vs  = {2'b00, v};
    assign bot = 12'(FLOOR_Y) - {2'b00, py};
    assign top = bot - 12'(SPRITE_SIZE);
    assign ctr = bot - 12'(HALF);
    assign dxw = hx - pxe - 11'(HALF);
    assign dyw = vs - ctr;
    assign dx  = dxw[DW-1:0];
    assign dy  = dyw[DW-1:0];
    assign sx  = dx * dx;
    assign sy  = dy * dy;
    assign d2s = {1'b0, sx} + {1'b0, sy};
    assign d2  = 11'(d2s);

    assign in_box = (hx >= pxe) && (hx < pxe + 11'(SPRITE_SIZE)) &&
                    (vs >= top) && (vs < bot);
    assign ring[g]  = in_box && (d2 < RING_R2);
    assign heart[g] = ring[g] && (d2 < pulse);
  end

  logic       any, win_heart;
  logic [1:0] win;

  // Scan downward so the lowest-index ring is the one left standing.
  always_comb begin
    any       = 1'b0;
    win       = '0;
    win_heart = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (ring[i]) begin
        any       = 1'b1;
        win       = 2'(i);
        win_heart = heart[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit       <= 1'b0;
      hit_heart <= 1'b0;
      hit_id    <= '0;
    end else begin
      hit       <= any;
      hit_heart <= win_heart;
      hit_id    <= win;
    end
  end

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Scoreboard bench for bounce_sprite_engine: cycle-tagged expectations,
// checked by an independent negedge monitor.
module tb_bounce_sprite_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_end;
  logic       enable;
  logic [9:0] h, v;
  logic       busy;
  logic [1:0] bounce;
  logic       hit, hit_heart;
  logic [1:0] hit_id;

  bounce_sprite_engine dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .enable(enable),
    .h(h), .v(v), .busy(busy), .bounce(bounce), .hit(hit),
    .hit_heart(hit_heart), .hit_id(hit_id)
  );

  always #5 clk = ~clk;

  typedef enum int {K_BUSY, K_BOUNCE, K_B0, K_HIT, K_X0, K_Y0, K_V0,
                    K_D0, K_X1, K_Y1, K_V1, K_PULSE} kind_e;

  typedef struct {
    int          at;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  item_t it;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int at, kind_e k, logic [31:0] e, string nm);
    item_t n;
    int idx;
    n.at = at; n.kind = k; n.exp = e; n.name = nm;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].at > at) idx--;
    sb.insert(idx, n);
  endfunction

  function automatic logic [31:0] sample(kind_e k);
    case (k)
      K_BUSY:   return {31'd0, busy};
      K_BOUNCE: return {30'd0, bounce};
      K_B0:     return {31'd0, bounce[0]};
      K_HIT:    return {28'd0, hit, hit_heart, hit_id};
      K_X0:     return {20'd0, dut.x[0]};
      K_Y0:     return {20'd0, dut.y[0]};
      K_V0:     return {24'd0, dut.vel[0]};
      K_D0:     return {31'd0, dut.dir[0]};
      K_X1:     return {20'd0, dut.x[1]};
      K_Y1:     return {20'd0, dut.y[1]};
      K_V1:     return {24'd0, dut.vel[1]};
      K_PULSE:  return {21'd0, dut.pulse};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      logic [31:0] act;
      it = sb.pop_front();
      checks++;
      if (it.at < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                 it.name, it.at, cyc);
      end else begin
        act = sample(it.kind);
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s @%0d: got %0d (0x%0h) expected %0d (0x%0h)",
                   it.name, cyc, act, act, it.exp, it.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe frame_end at current cycle n; returns at cycle n+4.
  task automatic frame(input logic en, input bit hold);
    enable    = en;
    frame_end = 1'b1;
    step();
    if (!hold) frame_end = 1'b0;
    step();
    frame_end = 1'b0;
    step();
    step();
    enable = 1'b1;
  endtask

  task automatic probe(input int ph, input int pv, input logic [3:0] e,
                       input string nm);
    push(cyc + 1, K_HIT, {28'd0, e}, nm);
    h = 10'(ph);
    v = 10'(pv);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push_reset_state(input int at);
    push(at, K_BUSY,   0,    "rst_busy");
    push(at, K_BOUNCE, 0,    "rst_bounce");
    push(at, K_HIT,    0,    "rst_hit");
    push(at, K_X0,     0,    "rst_x0");
    push(at, K_Y0,     0,    "rst_y0");
    push(at, K_V0,     21,   "rst_v0");
    push(at, K_D0,     1,    "rst_d0");
    push(at, K_X1,     1216, "rst_x1");
    push(at, K_V1,     20,   "rst_v1");
    push(at, K_PULSE,  9,    "rst_pulse");
  endtask

  int n;

  initial begin
    reset = 1'b1; frame_end = 1'b0; enable = 1'b1; h = '0; v = '0;
    step();
    push_reset_state(cyc);
    step();
    reset = 1'b0;
    step();

    // Single frame from reset: two busy cycles, both sprites stepped.
    n = cyc;
    push(n,     K_BUSY, 0, "f1_busy_n");
    push(n + 1, K_BUSY, 1, "f1_busy_n1");
    push(n + 2, K_BUSY, 1, "f1_busy_n2");
    push(n + 3, K_BUSY, 0, "f1_busy_n3");
    push(n + 3, K_X0, 9,           "f1_x0");
    push(n + 3, K_Y0, 21,          "f1_y0");
    push(n + 3, K_V0, 20,          "f1_v0");
    push(n + 3, K_X1, 1225,        "f1_x1");
    push(n + 3, K_Y1, 20,          "f1_y1");
    push(n + 3, K_V1, 19,          "f1_v1");
    push(n + 3, K_PULSE, 19,       "f1_pulse");
    frame(1'b1, 1'b0);

    // Frame with enable low: nothing moves, pulse frozen.
    n = cyc;
    push(n + 1, K_BUSY, 0,   "frz_busy");
    push(n + 3, K_X0, 9,     "frz_x0");
    push(n + 3, K_PULSE, 19, "frz_pulse");
    frame(1'b0, 1'b0);

    // Hit tracking with enable low, sprites at px 2/py 21 and px 306/py 20.
    enable = 1'b0;
    probe(18,  347, 4'b1100, "hit_s0_center");
    probe(22,  347, 4'b1100, "hit_s0_d16_heart");
    probe(322, 348, 4'b1101, "hit_s1_center");
    probe(2,   331, 4'b0000, "hit_s0_corner");
    enable = 1'b1;

    do_reset();

    // Reset geometry: sprite0 px 0, sprite1 px 304, both on floor, pulse 9.
    probe(16,  368, 4'b1100, "r_s0_center");
    probe(0,   352, 4'b0000, "r_s0_corner");
    probe(320, 368, 4'b1101, "r_s1_center");
    probe(20,  368, 4'b1000, "r_s0_ring_noheart");
    probe(16,  384, 4'b0000, "r_s0_below_box");
    probe(16,  383, 4'b1000, "r_s0_bottom_row");
    probe(31,  368, 4'b1000, "r_s0_right_col");
    probe(32,  368, 4'b0000, "r_s0_past_right");

    // Long run: landing on frame 43, right wall on frame 271.
    for (int k = 1; k <= 272; k++) begin
      n = cyc;
      if (k <= 44) begin
        push(n + 2, K_B0, (k == 43) ? 1 : 0, "b0_pulse");
        push(n + 3, K_B0, 0,                 "b0_clear");
      end
      if (k == 42) begin
        push(n + 3, K_Y0, 21,          "f42_y0");
        push(n + 3, K_V0, 32'h0000_00EB, "f42_v0");
      end
      if (k == 43) begin
        push(n + 3, K_Y0, 0,  "f43_y0");
        push(n + 3, K_V0, 21, "f43_v0");
      end
      if (k == 270) begin
        push(n + 3, K_X0, 2430, "f270_x0");
        push(n + 3, K_D0, 1,    "f270_d0");
      end
      if (k == 271) begin
        push(n + 3, K_X0, 2432, "f271_x0");
        push(n + 3, K_D0, 0,    "f271_d0");
      end
      if (k == 272) begin
        push(n + 3, K_X0, 2423, "f272_x0");
        push(n + 3, K_D0, 0,    "f272_d0");
      end
      frame(1'b1, 1'b0);
    end

    // Reset during the first update cycle aborts the run.
    n = cyc;
    h = 10'd16;
    v = 10'd368;
    push(n + 1, K_BUSY, 1, "ab_busy_before");
    push_reset_state(n + 2);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // frame_end held into the busy window starts only one run.
    n = cyc;
    push(n + 1, K_BUSY, 1,    "dbl_busy_n1");
    push(n + 2, K_BUSY, 1,    "dbl_busy_n2");
    push(n + 3, K_BUSY, 0,    "dbl_busy_n3");
    push(n + 4, K_BUSY, 0,    "dbl_busy_n4");
    push(n + 4, K_X0, 9,      "dbl_x0");
    push(n + 4, K_X1, 1225,   "dbl_x1");
    push(n + 4, K_PULSE, 19,  "dbl_pulse");
    frame(1'b1, 1'b1);
    step();

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never reached", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
